// File: rtl/vga_scanout_if.sv
// Bundle between vga_scanout and its surroundings: BRAM read port, VGA pins,
// frame marker and read-only taps of the raster counters.
interface vga_scanout_if;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;
    logic [9:0]  dbg_h_cnt;
    logic [9:0]  dbg_v_cnt;

    // Handshake-free streaming port: the scanout presents rd_addr every pixel
    // tick and samples rd_data one pixel tick later; there is no valid/ready.
    modport master (
        output rd_addr,
        input  rd_data,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output frame_start,
        output dbg_h_cnt,
        output dbg_v_cnt
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  frame_start,
        input  dbg_h_cnt,
        input  dbg_v_cnt
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator that centres a framebuffer window in the active area,
// reading pixels from a 1-cycle-latency BRAM through a two-tick pipeline.
module vga_scanout #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X0   = 170,
    parameter int WIN_Y0   = 140,
    parameter int WIN_W    = 300,
    parameter int WIN_H    = 200
) (
    input  logic          DCLK,
    input  logic          RESET,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [15:0]      rd_addr_q, rd_addr_d;
    logic             win_s1_q, win_s1_d;
    logic             hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             frame_start_q, frame_start_d;

    logic        tick, h_wrap, v_wrap;
    logic        active, in_win, hsync_raw, vsync_raw;
    logic [16:0] col_off, row_off, win_addr;
    logic        unused_bits;

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap = (h_q == 10'(H_TOTAL - 1));
    assign v_wrap = (v_q == 10'(V_TOTAL - 1));

    assign active    = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    assign in_win    = active
                    && (h_q >= 10'(WIN_X0)) && (h_q < 10'(WIN_X0 + WIN_W))
                    && (v_q >= 10'(WIN_Y0)) && (v_q < 10'(WIN_Y0 + WIN_H));
    assign hsync_raw = (h_q >= 10'(HS_START)) && (h_q < 10'(HS_START + H_SYNC));
    assign vsync_raw = (v_q >= 10'(VS_START)) && (v_q < 10'(VS_START + V_SYNC));

    // Offsets wrap harmlessly outside the window; in_win masks the result.
    assign col_off  = {7'd0, h_q - 10'(WIN_X0)};
    assign row_off  = {7'd0, v_q - 10'(WIN_Y0)};
    assign win_addr = row_off * 17'(WIN_W) + col_off;

    assign unused_bits = ^{win_addr[16], bus.rd_data[15:12]};

    always_comb begin
        div_d         = tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        rd_addr_d     = rd_addr_q;
        win_s1_d      = win_s1_q;
        hs_s1_d       = hs_s1_q;
        vs_s1_d       = vs_s1_q;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        frame_start_d = tick && h_wrap && v_wrap;
        if (tick) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            rd_addr_d = in_win ? win_addr[15:0] : '0;
            win_s1_d  = in_win;
            hs_s1_d   = ~hsync_raw;
            vs_s1_d   = ~vsync_raw;
            // BRAM data for the address issued last tick has been stable for CLK_DIV-1 cycles.
            rgb_d     = win_s1_q ? bus.rd_data[11:0] : 12'h000;
            hs_d      = hs_s1_q;
            vs_d      = vs_s1_q;
        end
    end

    always_ff @(posedge DCLK) begin
        if (RESET) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            rd_addr_q     <= '0;
            win_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= rd_addr_d;
            win_s1_q      <= win_s1_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = frame_start_q;
    assign bus.dbg_h_cnt   = h_q;
    assign bus.dbg_v_cnt   = v_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster so whole frames fit in a short run;
// expectations come from position-in-time arithmetic over the raster.
module tb_vga_scanout;
    localparam int CD  = 3;
    localparam int HA  = 20, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA  = 12, VFP = 2, VSY = 2, VBP = 1;
    localparam int WX0 = 5, WY0 = 3, WW = 8, WH = 6;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int NW  = WW * WH;
    localparam int FRAME_P = HT * VT;
    localparam int FRAME   = FRAME_P * CD;
    localparam int HS_FALL = (HA + HFP + 2) * CD;
    localparam int VS_FALL = ((VA + VFP) * HT + 2) * CD;

    logic DCLK  = 1'b0;
    logic RESET = 1'b1;
    int   kk    = 0;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] mem [0:NW-1];

    vga_scanout_if bus();

    vga_scanout #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_W(WW), .WIN_H(WH)
    ) dut (
        .DCLK(DCLK),
        .RESET(RESET),
        .bus(bus)
    );

    // ---- clock / reset / BRAM model ----
    always #5 DCLK = ~DCLK;

    always @(posedge DCLK) begin
        if (RESET) kk <= 0;
        else       kk <= kk + 1;
        bus.rd_data <= (int'(bus.rd_addr) < NW) ? mem[bus.rd_addr[5:0]] : 16'hDEAD;
    end

    // ---- reference model: outputs as a function of DCLKs since reset ----
    function automatic int pos_h(int p); return p % HT; endfunction
    function automatic int pos_v(int p); return (p / HT) % VT; endfunction

    function automatic bit m_win(int p);
        int h = pos_h(p);
        int v = pos_v(p);
        return (h < HA) && (v < VA) && (h >= WX0) && (h < WX0 + WW) && (v >= WY0) && (v < WY0 + WH);
    endfunction

    function automatic logic [15:0] m_addr(int p);
        if (!m_win(p)) return 16'd0;
        return 16'((pos_v(p) - WY0) * WW + (pos_h(p) - WX0));
    endfunction

    function automatic logic [15:0] m_raddr(int k);
        if (k / CD < 1) return 16'd0;
        return m_addr(k / CD - 1);
    endfunction

    function automatic logic [11:0] m_rgb(int k);
        logic [15:0] w;
        int t = k / CD;
        if (t < 2 || !m_win(t - 2)) return 12'h000;
        w = mem[int'(m_addr(t - 2))];
        return w[11:0];
    endfunction

    function automatic logic m_hs(int k);
        int h;
        if (k / CD < 2) return 1'b1;
        h = pos_h(k / CD - 2);
        return !((h >= HA + HFP) && (h < HA + HFP + HSY));
    endfunction

    function automatic logic m_vs(int k);
        int v;
        if (k / CD < 2) return 1'b1;
        v = pos_v(k / CD - 2);
        return !((v >= VA + VFP) && (v < VA + VFP + VSY));
    endfunction

    function automatic logic m_fs(int k);
        return (k >= CD) && (k % CD == 0) && ((k / CD) % FRAME_P == 0);
    endfunction

    // ---- drivers ----
    task automatic do_reset(input int n);
        @(negedge DCLK);
        RESET = 1'b1;
        repeat (n) @(negedge DCLK);
        RESET = 1'b0;
    endtask

    task automatic wait_kk(input int target);
        for (int i = 0; i < 20 * FRAME && kk < target; i++) @(negedge DCLK);
    endtask

    task automatic measure_first_hs(output int fall_k, output int rise_k, output int dirty);
        logic prev = bus.vga_hs;
        fall_k = -1;
        rise_k = -1;
        dirty  = 0;
        for (int i = 0; i < 4 * HT * CD && rise_k < 0; i++) begin
            @(negedge DCLK);
            if (fall_k < 0 && ({bus.vga_r, bus.vga_g, bus.vga_b} != 12'h0 || bus.vga_vs !== 1'b1)) dirty++;
            if (prev === 1'b1 && bus.vga_hs === 1'b0 && fall_k < 0) fall_k = kk;
            if (prev === 1'b0 && bus.vga_hs === 1'b1 && fall_k >= 0) rise_k = kk;
            prev = bus.vga_hs;
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        int fk, rk, dirty;
        do_reset(3);
        total += 7;
        if (bus.rd_addr !== 16'd0) begin bad++; $display("FAIL rst_rd_addr got=%0h exp=0", bus.rd_addr); end
        if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h0) begin bad++; $display("FAIL rst_rgb got=%0h exp=0", {bus.vga_r, bus.vga_g, bus.vga_b}); end
        if (bus.vga_hs !== 1'b1) begin bad++; $display("FAIL rst_hs got=%0b exp=1", bus.vga_hs); end
        if (bus.vga_vs !== 1'b1) begin bad++; $display("FAIL rst_vs got=%0b exp=1", bus.vga_vs); end
        if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%0b exp=0", bus.frame_start); end
        if (bus.dbg_h_cnt !== 10'd0) begin bad++; $display("FAIL rst_h got=%0d exp=0", bus.dbg_h_cnt); end
        if (bus.dbg_v_cnt !== 10'd0) begin bad++; $display("FAIL rst_v got=%0d exp=0", bus.dbg_v_cnt); end
        repeat (CD - 1) @(negedge DCLK);
        total++;
        if (bus.dbg_h_cnt !== 10'd0) begin bad++; $display("FAIL hold_h got=%0d exp=0", bus.dbg_h_cnt); end
        @(negedge DCLK);
        total++;
        if (bus.dbg_h_cnt !== 10'd1) begin bad++; $display("FAIL first_tick_h got=%0d exp=1", bus.dbg_h_cnt); end
        measure_first_hs(fk, rk, dirty);
        total += 3;
        if (fk !== HS_FALL) begin bad++; $display("FAIL rst_hs_fall got=%0d exp=%0d", fk, HS_FALL); end
        if (rk - fk !== HSY * CD) begin bad++; $display("FAIL rst_hs_width got=%0d exp=%0d", rk - fk, HSY * CD); end
        if (dirty !== 0) begin bad++; $display("FAIL rst_quiet got=%0d exp=0", dirty); end
    endtask

    task automatic test_full_frame();
        int hs_falls = 0, vs_falls = 0, vs_fall = -1, vs_rise = -1;
        int fs_k[$];
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
        do_reset(1);
        for (int i = 0; i < 3 * FRAME && kk < 2 * FRAME + 2 * CD; i++) begin
            @(negedge DCLK);
            total += 7;
            if (bus.rd_addr !== m_raddr(kk)) begin bad++; $display("FAIL ff_rd_addr k=%0d got=%0h exp=%0h", kk, bus.rd_addr, m_raddr(kk)); end
            if ({bus.vga_r, bus.vga_g, bus.vga_b} !== m_rgb(kk)) begin bad++; $display("FAIL ff_rgb k=%0d got=%0h exp=%0h", kk, {bus.vga_r, bus.vga_g, bus.vga_b}, m_rgb(kk)); end
            if (bus.vga_hs !== m_hs(kk)) begin bad++; $display("FAIL ff_hs k=%0d got=%0b exp=%0b", kk, bus.vga_hs, m_hs(kk)); end
            if (bus.vga_vs !== m_vs(kk)) begin bad++; $display("FAIL ff_vs k=%0d got=%0b exp=%0b", kk, bus.vga_vs, m_vs(kk)); end
            if (bus.frame_start !== m_fs(kk)) begin bad++; $display("FAIL ff_fs k=%0d got=%0b exp=%0b", kk, bus.frame_start, m_fs(kk)); end
            if (int'(bus.dbg_h_cnt) !== pos_h(kk / CD)) begin bad++; $display("FAIL ff_h k=%0d got=%0d exp=%0d", kk, bus.dbg_h_cnt, pos_h(kk / CD)); end
            if (int'(bus.dbg_v_cnt) !== pos_v(kk / CD)) begin bad++; $display("FAIL ff_v k=%0d got=%0d exp=%0d", kk, bus.dbg_v_cnt, pos_v(kk / CD)); end
            if (kk <= FRAME) begin
                if (prev_hs === 1'b1 && bus.vga_hs === 1'b0) hs_falls++;
                if (prev_vs === 1'b1 && bus.vga_vs === 1'b0) begin vs_falls++; if (vs_fall < 0) vs_fall = kk; end
                if (prev_vs === 1'b0 && bus.vga_vs === 1'b1 && vs_rise < 0) vs_rise = kk;
            end
            if (bus.frame_start === 1'b1) fs_k.push_back(kk);
            prev_hs = bus.vga_hs;
            prev_vs = bus.vga_vs;
        end
        total += 7;
        if (hs_falls !== VT) begin bad++; $display("FAIL ff_hs_count got=%0d exp=%0d", hs_falls, VT); end
        if (vs_falls !== 1) begin bad++; $display("FAIL ff_vs_count got=%0d exp=1", vs_falls); end
        if (vs_fall !== VS_FALL) begin bad++; $display("FAIL ff_vs_fall got=%0d exp=%0d", vs_fall, VS_FALL); end
        if (vs_rise - vs_fall !== VSY * HT * CD) begin bad++; $display("FAIL ff_vs_width got=%0d exp=%0d", vs_rise - vs_fall, VSY * HT * CD); end
        if (fs_k.size() !== 2) begin bad++; $display("FAIL ff_fs_count got=%0d exp=2", fs_k.size()); end
        if (fs_k.size() < 1 || fs_k[0] !== FRAME) begin bad++; $display("FAIL ff_fs_first got=%0d exp=%0d", (fs_k.size() > 0) ? fs_k[0] : -1, FRAME); end
        if (fs_k.size() < 2 || fs_k[1] - fs_k[0] !== FRAME) begin bad++; $display("FAIL ff_fs_period got=%0d exp=%0d", (fs_k.size() > 1) ? fs_k[1] - fs_k[0] : -1, FRAME); end
    endtask

    task automatic test_window_addr();
        int th[5] = '{WX0, WX0 + WW - 1, WX0, WX0 + WW - 1, WX0};
        int tv[5] = '{WY0, WY0, WY0 + 1, WY0 + WH - 1, WY0};
        int tf[5] = '{0, 0, 0, 0, 1};
        int te[5] = '{0, WW - 1, WW, NW - 1, 0};
        int p;
        for (int i = 0; i < NW; i++) mem[i] = 16'(i);
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            p = tf[i] * FRAME_P + tv[i] * HT + th[i];
            wait_kk((p + 1) * CD);
            total += 2;
            if (kk !== (p + 1) * CD) begin bad++; $display("FAIL win_wait%0d got=%0d exp=%0d", i, kk, (p + 1) * CD); end
            if (int'(bus.rd_addr) !== te[i]) begin bad++; $display("FAIL win_addr%0d got=%0d exp=%0d", i, bus.rd_addr, te[i]); end
            wait_kk((p + 2) * CD);
            if (int'({bus.vga_r, bus.vga_g, bus.vga_b}) !== te[i]) begin bad++; $display("FAIL win_rgb%0d got=%0h exp=%0h", i, {bus.vga_r, bus.vga_g, bus.vga_b}, te[i]); end
        end
    endtask

    task automatic test_outside();
        int tp[7] = '{(WY0 - 1) * HT + WX0, WY0 * HT + WX0 - 1, WY0 * HT + WX0, WY0 * HT + WX0 + WW,
                      WY0 * HT + HA + 1, (WY0 + WH) * HT + WX0, (VA + 1) * HT + WX0};
        logic [11:0] te[7] = '{12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
        logic [11:0] exp_rgb;
        int idx = 0;
        for (int i = 0; i < NW; i++) mem[i] = 16'hFFFF;
        do_reset(1);
        for (int i = 0; i < 2 * FRAME && kk < FRAME + 2 * CD; i++) begin
            @(negedge DCLK);
            exp_rgb = (kk / CD >= 2 && m_win(kk / CD - 2)) ? 12'hFFF : 12'h000;
            total++;
            if ({bus.vga_r, bus.vga_g, bus.vga_b} !== exp_rgb) begin bad++; $display("FAIL out_sweep k=%0d got=%0h exp=%0h", kk, {bus.vga_r, bus.vga_g, bus.vga_b}, exp_rgb); end
            if (idx < 7 && kk == (tp[idx] + 2) * CD) begin
                total++;
                if ({bus.vga_r, bus.vga_g, bus.vga_b} !== te[idx]) begin bad++; $display("FAIL out_edge%0d got=%0h exp=%0h", idx, {bus.vga_r, bus.vga_g, bus.vga_b}, te[idx]); end
                idx++;
            end
        end
        total++;
        if (idx !== 7) begin bad++; $display("FAIL out_edges_seen got=%0d exp=7", idx); end
    endtask

    task automatic test_colour();
        int p0 = WY0 * HT + WX0;
        for (int i = 0; i < NW; i++) mem[i] = 16'h0000;
        mem[0] = 16'h000F;
        mem[1] = 16'h00F0;
        do_reset(1);
        wait_kk((p0 + 2) * CD);
        total += 3;
        if (bus.vga_r !== 4'h0) begin bad++; $display("FAIL col0_r got=%0h exp=0", bus.vga_r); end
        if (bus.vga_g !== 4'h0) begin bad++; $display("FAIL col0_g got=%0h exp=0", bus.vga_g); end
        if (bus.vga_b !== 4'hF) begin bad++; $display("FAIL col0_b got=%0h exp=f", bus.vga_b); end
        wait_kk((p0 + 3) * CD);
        total += 3;
        if (bus.vga_r !== 4'h0) begin bad++; $display("FAIL col1_r got=%0h exp=0", bus.vga_r); end
        if (bus.vga_g !== 4'hF) begin bad++; $display("FAIL col1_g got=%0h exp=f", bus.vga_g); end
        if (bus.vga_b !== 4'h0) begin bad++; $display("FAIL col1_b got=%0h exp=0", bus.vga_b); end
    endtask

    task automatic test_mid_reset();
        int fk, rk, dirty, fs_n = 0, fs_at = -1, vs_fall = -1;
        logic prev_vs = 1'b1;
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
        do_reset(1);
        wait_kk((8 * HT + 12) * CD + 1);
        RESET = 1'b1;
        @(negedge DCLK);
        RESET = 1'b0;
        total += 7;
        if (bus.rd_addr !== 16'd0) begin bad++; $display("FAIL mid_rd_addr got=%0h exp=0", bus.rd_addr); end
        if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h0) begin bad++; $display("FAIL mid_rgb got=%0h exp=0", {bus.vga_r, bus.vga_g, bus.vga_b}); end
        if (bus.vga_hs !== 1'b1) begin bad++; $display("FAIL mid_hs got=%0b exp=1", bus.vga_hs); end
        if (bus.vga_vs !== 1'b1) begin bad++; $display("FAIL mid_vs got=%0b exp=1", bus.vga_vs); end
        if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL mid_fs got=%0b exp=0", bus.frame_start); end
        if (bus.dbg_h_cnt !== 10'd0) begin bad++; $display("FAIL mid_h got=%0d exp=0", bus.dbg_h_cnt); end
        if (bus.dbg_v_cnt !== 10'd0) begin bad++; $display("FAIL mid_v got=%0d exp=0", bus.dbg_v_cnt); end
        measure_first_hs(fk, rk, dirty);
        total += 3;
        if (fk !== HS_FALL) begin bad++; $display("FAIL mid_hs_fall got=%0d exp=%0d", fk, HS_FALL); end
        if (rk - fk !== HSY * CD) begin bad++; $display("FAIL mid_hs_width got=%0d exp=%0d", rk - fk, HSY * CD); end
        if (dirty !== 0) begin bad++; $display("FAIL mid_quiet got=%0d exp=0", dirty); end
        for (int i = 0; i < 2 * FRAME && kk < FRAME + CD; i++) begin
            @(negedge DCLK);
            if (bus.frame_start === 1'b1) begin fs_n++; fs_at = kk; end
            if (prev_vs === 1'b1 && bus.vga_vs === 1'b0 && vs_fall < 0) vs_fall = kk;
            prev_vs = bus.vga_vs;
        end
        total += 3;
        if (vs_fall !== VS_FALL) begin bad++; $display("FAIL mid_vs_fall got=%0d exp=%0d", vs_fall, VS_FALL); end
        if (fs_n !== 1) begin bad++; $display("FAIL mid_fs_count got=%0d exp=1", fs_n); end
        if (fs_at !== FRAME) begin bad++; $display("FAIL mid_fs_at got=%0d exp=%0d", fs_at, FRAME); end
    endtask

    // ---- sequence and report ----
    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 16'h0000;
        test_reset();
        test_full_frame();
        test_window_addr();
        test_outside();
        test_colour();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side reader for the 300x200 waveform framebuffer BRAM. Generates 640x480@60 VGA timing from DCLK through an internal pixel-tick divider, fetches framebuffer words over the BRAM read port, and centres the 300x200 window in the active area. Pixels outside the window are black. Sits directly downstream of the waveform renderer, which owns the BRAM write port.

## Interface
Parameters:
- CLK_DIV, 4: DCLK cycles per pixel; must be ≥2.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- WIN_X0, 170; WIN_Y0, 140: top-left of the framebuffer window in active coordinates.
- WIN_W, 300; WIN_H, 200: window size; must equal the framebuffer geometry.

Ports:
- DCLK  in  1  system clock; the only clock. All logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- rd_addr  out  16  BRAM read address, row*WIN_W+col. BRAM read latency is 1 DCLK.
- rd_data  in  16  BRAM read data. [11:8]=R, [7:4]=G, [3:0]=B; [15:12] ignored.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- vga_hs, vga_vs  out  1 each  sync outputs, active-low.
- frame_start  out  1  one-DCLK pulse at the start of each frame.

## Operation
- The divider counts 0..CLK_DIV-1 and wraps. tick=1 when div==CLK_DIV-1.
- On tick:
  - h_cnt increments over 0..799 (H total 800) and wraps to 0.
  - On wrap from 799, v_cnt increments over 0..524 (V total 525) and wraps to 0.
- Derived signals:
  - active = h_cnt<640 && v_cnt<480.
  - in_win = active && WIN_X0≤h_cnt<WIN_X0+WIN_W && WIN_Y0≤v_cnt<WIN_Y0+WIN_H.
  - hsync_raw = 656≤h_cnt<752.
  - vsync_raw = 490≤v_cnt<492.
- Pipeline stage 1, registered on tick from the current (h_cnt, v_cnt):
  - rd_addr <= in_win ? (v_cnt-WIN_Y0)*WIN_W + (h_cnt-WIN_X0) : 0.
  - win_d <= in_win.
  - hs_d <= ~hsync_raw; vs_d <= ~vsync_raw.
- Pipeline stage 2, registered on the next tick:
  - {vga_r, vga_g, vga_b} <= win_d ? rd_data[11:0] : 12'h000.
  - vga_hs <= hs_d; vga_vs <= vs_d.
- rd_data is sampled CLK_DIV DCLKs after rd_addr updates. CLK_DIV≥2 therefore covers the 1-cycle BRAM latency.
- Address arithmetic is unsigned, max 59999, fits in 16 bits. Use a 17-bit intermediate for the multiply-add; no saturation is needed.
- frame_start=1 for exactly one DCLK: the cycle after the tick on which (h_cnt, v_cnt) wraps (799,524)->(0,0).
- Blanking (active=0) always gives RGB 0, whatever rd_data holds.

## Timing
- Reset values (cycle after RESET sampled high):
  - div=0, h_cnt=0, v_cnt=0, rd_addr=0.
  - win_d=0, hs_d=1, vs_d=1.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_start=0.
- Reset mid-frame aborts immediately. No partial line is completed. No frame_start is emitted due to reset.
- First tick comes CLK_DIV DCLKs after RESET deasserts. Counter (0,0) holds for the first CLK_DIV cycles.
- Counter-to-pin latency is 2 ticks (2*CLK_DIV DCLKs), identical for RGB, hs and vs, so they stay aligned.
- Line period is 800*CLK_DIV DCLKs. Frame period is 525 lines.
- Window wrap:
  - Last window pixel (h=469, v=339) addresses 59999.
  - The next in-window pixel (h=170, v=140, next frame) addresses 0.
- A simultaneous h wrap and v wrap on the same tick is a single event producing one frame_start.

## Test plan
- Reset then run: RESET high 3 cycles, then low. vga_hs=vga_vs=1 and RGB=0 until the first sync region. The first hs low pulse begins at DCLK (656+2)*4 after deassert and lasts 96*4 DCLKs.
- Full frame: run 800*525*4 DCLKs.
  - Exactly 525 hs pulses and one vs pulse, 2 lines long, starting at line 490 (+2-tick pipeline).
  - frame_start period = 1,680,000 DCLKs.
- Window addressing: BRAM model returns data=addr[11:0].
  - rd_addr=0 at h=170, v=140; rd_addr=299 at h=469, v=140; rd_addr=300 at h=170, v=141; rd_addr=59999 at h=469, v=339.
  - Output RGB matches each address 2 ticks later.
- Outside window: BRAM model returns 16'hFFFF.
  - RGB=0 at h=169, h=470, v=139, v=340, and everywhere in blanking.
  - RGB=12'hFFF inside the window; bits [15:12] are not propagated.
- Colour mapping: the word at addr 0 is 16'h000F, at addr 1 is 16'h00F0 → first two window pixels are (r,g,b)=(0,0,F) then (0,F,0).
- Mid-frame reset: assert RESET at h=300, v=250 for 1 cycle.
  - Next cycle: all outputs equal their reset values and counters are 0.
  - The following frame timing matches the reset-then-run scenario exactly.
